pipelined_control_unit: RTL and testbench

- Next-generation control unit for the 5-stage MIPS core: decodes opcode/funct in D and resolves branch/jump redirects in D.
- Carries the control bundle through its own D/E, E/M and M/W registers; the datapath receives stage-aligned controls.
- Adds BNE, ADDI/ANDI/ORI/SLTI, JAL and a multi-cycle MULT with HI/LO interlock. Exports a multiply stall to the hazard unit.

---
 rtl/cu_pkg.sv | 102 ++++++++++
 rtl/pipelined_control_unit_mul_seq.sv | 57 +++++
 rtl/pipelined_control_unit.sv | 144 ++++++++++++++
 tb/tb_pipelined_control_unit.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the pipelined control unit: opcode/funct codes, ALU encodings,
// the stage-by-stage control bundle, the multiply FSM states and the decode helpers.
package cu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_op_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    // Bundles nest so each pipeline register simply forwards the next stage's slice.
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic hilo_sel;
    } w_ctrl_t;

    typedef struct packed {
        logic    mem_write;
        w_ctrl_t w;
    } m_ctrl_t;

    typedef struct packed {
        alu_op_e alu_ctrl;
        logic    alu_src;
        logic    reg_dst;
        logic    link;
        logic    imm_zero_ext;
        logic    mul_start;
        m_ctrl_t m;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin c.reg_dst = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_ADD; end
                    FN_SUB:  begin c.reg_dst = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_SUB; end
                    FN_AND:  begin c.reg_dst = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_AND; end
                    FN_OR:   begin c.reg_dst = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_OR;  end
                    FN_SLT:  begin c.reg_dst = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_SLT; end
                    FN_MULT: c.mul_start = 1'b1;
                    FN_MFHI: begin c.reg_dst = 1'b1; c.m.w.reg_write = 1'b1; c.m.w.hilo_sel = 1'b1; end
                    FN_MFLO: begin c.reg_dst = 1'b1; c.m.w.reg_write = 1'b1; end
                    default: c = '0;
                endcase
            end
            OP_ADDI: begin c.alu_src = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_ADD; end
            OP_ANDI: begin
                c.alu_src = 1'b1; c.imm_zero_ext = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_AND;
            end
            OP_ORI: begin
                c.alu_src = 1'b1; c.imm_zero_ext = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_OR;
            end
            OP_SLTI: begin c.alu_src = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_SLT; end
            OP_LW: begin
                c.alu_src = 1'b1; c.m.w.mem_to_reg = 1'b1; c.m.w.reg_write = 1'b1; c.alu_ctrl = ALU_ADD;
            end
            OP_SW:   begin c.alu_src = 1'b1; c.m.mem_write = 1'b1; c.alu_ctrl = ALU_ADD; end
            OP_BEQ, OP_BNE: c.alu_ctrl = ALU_SUB;
            OP_JAL:  begin c.link = 1'b1; c.m.w.reg_write = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Instructions that touch HI/LO and must wait for the multiplier.
    function automatic logic is_mul_op(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && ((funct == FN_MULT) || (funct == FN_MFHI) || (funct == FN_MFLO));
    endfunction

endpackage

// File: rtl/pipelined_control_unit_mul_seq.sv
// Multiply sequencer: tracks multiplier occupancy after a MULT starts in E and
// raises the HI/LO interlock for MULT/MFHI/MFLO waiting in D.
module mul_seq_fsm
    import cu_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mul_start_e,
    input  logic mul_op_d,
    output logic mul_busy,
    output logic stall_mul_d
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

    mul_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MUL_IDLE: begin
                if (mul_start_e) begin
                    state_d = MUL_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            MUL_BUSY: begin
                // Leaving on cnt==0 gives exactly MUL_LATENCY busy cycles.
                if (cnt_q == 4'd0) begin
                    state_d = MUL_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mul_busy    = (state_q == MUL_BUSY);
    // Including mul_start_e closes the one-cycle gap before the FSM registers BUSY.
    assign stall_mul_d = mul_op_d && (mul_busy || mul_start_e) && !rst;

endmodule

// File: rtl/pipelined_control_unit.sv
// MIPS 5-stage control unit: D-stage decode/redirect, D/E-E/M-M/W control registers and
// multiply interlock. Optional performance counters are built when CU_PERF_CNT_EN is defined.
module pipelined_control_unit
    import cu_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            OpCode,
    input  logic [5:0]            Funct,
    input  logic                  EqualD,
    input  logic                  FlushE,
    input  logic                  StallD,
    output logic                  PCSrcD,
    output logic                  jumpD,
    output logic                  clearD,
    output logic                  StallMulD,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic                  ALUSrcE,
    output logic                  RegDstE,
    output logic                  LinkE,
    output logic                  ImmZeroExtE,
    output logic                  MulStartE,
    output logic                  MemWriteM,
    output logic                  MemtoRegM,
    output logic                  RegWriteM,
    output logic                  MemtoRegW,
    output logic                  RegWriteW,
    output logic                  HiLoSelW,
    output logic                  MulBusy,
    output logic [CNT_W-1:0]      BrTakenCnt,
    output logic [CNT_W-1:0]      MulStallCnt
);

    ctrl_t   dec_d;
    ctrl_t   de_d, de_q;
    m_ctrl_t em_d, em_q;
    w_ctrl_t mw_d, mw_q;

    logic branch_taken_d;
    logic jump_dec_d;
    logic redirect_en;
    logic mul_op_d;
    logic mul_start_e;

    always_comb begin
        dec_d          = decode(OpCode, Funct);
        mul_op_d       = is_mul_op(OpCode, Funct);
        jump_dec_d     = (OpCode == OP_J) || (OpCode == OP_JAL);
        branch_taken_d = ((OpCode == OP_BEQ) && EqualD) || ((OpCode == OP_BNE) && !EqualD);
        // A held D instruction must not redirect; reset also silences it asynchronously.
        redirect_en    = !StallD && !rst;
    end

    assign PCSrcD = branch_taken_d && redirect_en;
    assign jumpD  = jump_dec_d && redirect_en;
    assign clearD = PCSrcD || jumpD;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        de_d = dec_d;
        if (FlushE || StallD) begin
            de_d = '0;
        end
        em_d = de_q.m;
        mw_d = em_q.w;
    end

    // NOTE: state updates use non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q <= '0;
            em_q <= '0;
            mw_q <= '0;
        end else begin
            de_q <= de_d;
            em_q <= em_d;
            mw_q <= mw_d;
        end
    end

    // A MULT sitting in E while FlushE is high becomes a bubble and never starts.
    assign mul_start_e = de_q.mul_start && !FlushE;

    mul_seq_fsm #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_seq (
        .clk         (clk),
        .rst         (rst),
        .mul_start_e (mul_start_e),
        .mul_op_d    (mul_op_d),
        .mul_busy    (MulBusy),
        .stall_mul_d (StallMulD)
    );

    assign ALUControlE = ALU_CTRL_W'(de_q.alu_ctrl);
    assign ALUSrcE     = de_q.alu_src;
    assign RegDstE     = de_q.reg_dst;
    assign LinkE       = de_q.link;
    assign ImmZeroExtE = de_q.imm_zero_ext;
    assign MulStartE   = mul_start_e;
    assign MemWriteM   = em_q.mem_write;
    assign MemtoRegM   = em_q.w.mem_to_reg;
    assign RegWriteM   = em_q.w.reg_write;
    assign MemtoRegW   = mw_q.mem_to_reg;
    assign RegWriteW   = mw_q.reg_write;
    assign HiLoSelW    = mw_q.hilo_sel;

`ifdef CU_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mul_cnt_d = mul_cnt_q;
        if (PCSrcD && !(&br_cnt_q)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (StallMulD && !(&mul_cnt_q)) begin
            mul_cnt_d = mul_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mul_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign BrTakenCnt  = br_cnt_q;
    assign MulStallCnt = mul_cnt_q;
`else
    assign BrTakenCnt  = '0;
    assign MulStallCnt = '0;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed scenarios plus a randomized run
// against an instruction-level reference model; the bench also plays the hazard unit.
module tb_pipelined_control_unit;

    localparam int ALU_W   = 4;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 32;
`ifdef CU_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic             clk, rst;
    logic [5:0]       OpCode, Funct;
    logic             EqualD, FlushE, StallD;
    logic             PCSrcD, jumpD, clearD, StallMulD;
    logic [ALU_W-1:0] ALUControlE;
    logic             ALUSrcE, RegDstE, LinkE, ImmZeroExtE, MulStartE;
    logic             MemWriteM, MemtoRegM, RegWriteM;
    logic             MemtoRegW, RegWriteW, HiLoSelW, MulBusy;
    logic [CNT_W-1:0] BrTakenCnt, MulStallCnt;

    pipelined_control_unit #(
        .ALU_CTRL_W  (ALU_W),
        .MUL_LATENCY (MUL_LAT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .EqualD      (EqualD),
        .FlushE      (FlushE),
        .StallD      (StallD),
        .PCSrcD      (PCSrcD),
        .jumpD       (jumpD),
        .clearD      (clearD),
        .StallMulD   (StallMulD),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .RegDstE     (RegDstE),
        .LinkE       (LinkE),
        .ImmZeroExtE (ImmZeroExtE),
        .MulStartE   (MulStartE),
        .MemWriteM   (MemWriteM),
        .MemtoRegM   (MemtoRegM),
        .RegWriteM   (RegWriteM),
        .MemtoRegW   (MemtoRegW),
        .RegWriteW   (RegWriteW),
        .HiLoSelW    (HiLoSelW),
        .MulBusy     (MulBusy),
        .BrTakenCnt  (BrTakenCnt),
        .MulStallCnt (MulStallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [83:0] all_outs = {PCSrcD, jumpD, clearD, StallMulD, ALUControlE, ALUSrcE, RegDstE,
                            LinkE, ImmZeroExtE, MulStartE, MemWriteM, MemtoRegM, RegWriteM,
                            MemtoRegW, RegWriteW, HiLoSelW, MulBusy, BrTakenCnt, MulStallCnt};

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (instruction level) ----------------
    typedef enum {M_NOP, M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_MULT, M_MFHI, M_MFLO, M_ADDI,
                  M_ANDI, M_ORI, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL} mnem_e;

    typedef struct packed {
        logic [3:0] alu;
        logic alu_src, reg_dst, link, zext, mul_start, mem_write, mem_to_reg, reg_write, hilo;
    } exp_t;

    function automatic mnem_e classify(input logic [5:0] op, input logic [5:0] fn);
        mnem_e m;
        m = M_NOP;
        case (op)
            6'h00: case (fn)
                6'h20: m = M_ADD;  6'h22: m = M_SUB;  6'h24: m = M_AND;  6'h25: m = M_OR;
                6'h2A: m = M_SLT;  6'h18: m = M_MULT; 6'h10: m = M_MFHI; 6'h12: m = M_MFLO;
                default: m = M_NOP;
            endcase
            6'h08: m = M_ADDI; 6'h0C: m = M_ANDI; 6'h0D: m = M_ORI; 6'h0A: m = M_SLTI;
            6'h23: m = M_LW;   6'h2B: m = M_SW;   6'h04: m = M_BEQ; 6'h05: m = M_BNE;
            6'h02: m = M_J;    6'h03: m = M_JAL;
            default: m = M_NOP;
        endcase
        return m;
    endfunction

    function automatic exp_t expect_bundle(input mnem_e m);
        exp_t e;
        e = '0;
        e.reg_write  = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_MFHI, M_MFLO, M_ADDI,
                                 M_ANDI, M_ORI, M_SLTI, M_LW, M_JAL};
        e.reg_dst    = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_MFHI, M_MFLO};
        e.alu_src    = m inside {M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LW, M_SW};
        e.zext       = m inside {M_ANDI, M_ORI};
        e.link       = (m == M_JAL);
        e.mul_start  = (m == M_MULT);
        e.mem_write  = (m == M_SW);
        e.mem_to_reg = (m == M_LW);
        e.hilo       = (m == M_MFHI);
        if (m inside {M_ADD, M_ADDI, M_LW, M_SW})      e.alu = 4'b0010;
        else if (m inside {M_SUB, M_BEQ, M_BNE})       e.alu = 4'b0110;
        else if (m inside {M_OR, M_ORI})               e.alu = 4'b0001;
        else if (m inside {M_SLT, M_SLTI})             e.alu = 4'b0111;
        else                                           e.alu = 4'b0000;
        return e;
    endfunction

    function automatic logic [11:0] pick(input int idx);
        logic [11:0] r;
        case (idx)
            0: r = {6'h00, 6'h20};  1: r = {6'h00, 6'h22};  2: r = {6'h00, 6'h24};
            3: r = {6'h00, 6'h25};  4: r = {6'h00, 6'h2A};  5: r = {6'h00, 6'h18};
            6: r = {6'h00, 6'h10};  7: r = {6'h00, 6'h12};  8: r = {6'h08, 6'h00};
            9: r = {6'h0C, 6'h00};  10: r = {6'h0D, 6'h00}; 11: r = {6'h0A, 6'h00};
            12: r = {6'h23, 6'h00}; 13: r = {6'h2B, 6'h00}; 14: r = {6'h04, 6'h00};
            15: r = {6'h05, 6'h00}; 16: r = {6'h02, 6'h00}; 17: r = {6'h03, 6'h00};
            default: r = {6'h00, 6'h3F};
        endcase
        return r;
    endfunction

    exp_t e_exp, m_exp, w_exp, pend;
    int   mul_left;
    logic start_prev;
    logic exp_pcsrc, exp_jump, exp_clear, exp_stall, exp_start_e, exp_busy;
    int   br_cnt, ms_cnt, br_inc, ms_inc;
    logic stl;

    task automatic model_reset();
        e_exp = '0; m_exp = '0; w_exp = '0; pend = '0;
        mul_left = 0; start_prev = 1'b0;
        br_cnt = 0; ms_cnt = 0; br_inc = 0; ms_inc = 0;
    endtask

    // One D-stage cycle: advance the model past the last rising edge, drive the inputs, settle.
    // With hz=1 the bench acts as hazard unit and raises StallD whenever a MULT interlock is due.
    task automatic drive_cycle(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                               input logic fl, input logic st, input logic hz,
                               output logic stalled);
        mnem_e mn;
        logic  st_eff, taken;
        @(negedge clk);
        w_exp = m_exp;
        m_exp = e_exp;
        e_exp = pend;
        if (start_prev) mul_left = MUL_LAT;
        else if (mul_left > 0) mul_left = mul_left - 1;
        br_cnt = br_cnt + br_inc;
        ms_cnt = ms_cnt + ms_inc;

        mn          = classify(op, fn);
        exp_busy    = (mul_left > 0);
        exp_start_e = e_exp.mul_start && !fl;
        exp_stall   = (mn inside {M_MULT, M_MFHI, M_MFLO}) && (exp_busy || exp_start_e);
        st_eff      = st || (hz && exp_stall);
        taken       = ((mn == M_BEQ) && eq) || ((mn == M_BNE) && !eq);
        exp_pcsrc   = taken && !st_eff;
        exp_jump    = (mn inside {M_J, M_JAL}) && !st_eff;
        exp_clear   = exp_pcsrc || exp_jump;
        pend        = (fl || st_eff) ? exp_t'('0) : expect_bundle(mn);
        start_prev  = exp_start_e;
        br_inc      = exp_pcsrc ? 1 : 0;
        ms_inc      = exp_stall ? 1 : 0;

        OpCode = op; Funct = fn; EqualD = eq; FlushE = fl; StallD = st_eff;
        #1;
        stalled = st_eff;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        OpCode = 6'h00; Funct = 6'h00; EqualD = 1'b0; FlushE = 1'b0; StallD = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        OpCode = 6'h05; Funct = 6'h00; EqualD = 1'b0; FlushE = 1'b0; StallD = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", all_outs);
        end
        reset_dut();
    endtask

    task automatic test_lw();
        drive_cycle(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if ({ALUControlE, ALUSrcE} !== {4'b0010, 1'b1}) begin
            errors++;
            $display("FAIL lw_e_alu got=%b/%b want=0010/1", ALUControlE, ALUSrcE);
        end
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if ({MemtoRegM, MemWriteM} !== 2'b10) begin
            errors++;
            $display("FAIL lw_m got MemtoRegM=%b MemWriteM=%b want 1/0", MemtoRegM, MemWriteM);
        end
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if ({RegWriteW, MemtoRegW} !== 2'b11) begin
            errors++;
            $display("FAIL lw_w got RegWriteW=%b MemtoRegW=%b want 1/1", RegWriteW, MemtoRegW);
        end
    endtask

    task automatic test_redirect();
        drive_cycle(6'h05, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if ({PCSrcD, clearD, jumpD} !== 3'b110) begin
            errors++;
            $display("FAIL bne_ne got pcsrc/clear/jump=%b want 110", {PCSrcD, clearD, jumpD});
        end
        drive_cycle(6'h05, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if ({PCSrcD, clearD} !== 2'b00) begin
            errors++;
            $display("FAIL bne_eq got pcsrc/clear=%b want 00", {PCSrcD, clearD});
        end
        drive_cycle(6'h05, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, stl);
        checks++;
        if ({PCSrcD, clearD} !== 2'b00) begin
            errors++;
            $display("FAIL bne_stalled got pcsrc/clear=%b want 00", {PCSrcD, clearD});
        end
        drive_cycle(6'h04, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if ({PCSrcD, clearD} !== 2'b11) begin
            errors++;
            $display("FAIL beq_eq got pcsrc/clear=%b want 11", {PCSrcD, clearD});
        end
        drive_cycle(6'h03, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if ({jumpD, clearD, PCSrcD} !== 3'b110) begin
            errors++;
            $display("FAIL jal_d got jump/clear/pcsrc=%b want 110", {jumpD, clearD, PCSrcD});
        end
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if (LinkE !== 1'b1) begin
            errors++;
            $display("FAIL jal_link got LinkE=%b want 1", LinkE);
        end
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if (RegWriteM !== 1'b1) begin
            errors++;
            $display("FAIL jal_regwrite got RegWriteM=%b want 1", RegWriteM);
        end
    endtask

    task automatic test_mult_mflo();
        int   n, stall_cycles;
        logic last_busy;
        n = 0; stall_cycles = 0; last_busy = 1'b0;
        drive_cycle(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        do begin
            drive_cycle(6'h00, 6'h12, 1'b0, 1'b0, 1'b0, 1'b1, stl);
            checks++;
            if ({StallMulD, MulBusy} !== {exp_stall, exp_busy}) begin
                errors++;
                $display("FAIL mult_stall_cycle%0d got stall/busy=%b%b want %b%b", n,
                         StallMulD, MulBusy, exp_stall, exp_busy);
            end
            if (StallMulD === 1'b1) stall_cycles++;
            if (stl) last_busy = MulBusy;
            n++;
        end while (stl && n < 20);
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL mult_timeout got %0d stalled cycles want release", n);
        end
        checks++;
        if (stall_cycles != 5) begin
            errors++;
            $display("FAIL mult_stall_len got %0d want 5", stall_cycles);
        end
        checks++;
        if ({last_busy, MulBusy} !== 2'b10) begin
            errors++;
            $display("FAIL mult_busy_fall got last_busy=%b busy=%b want 1/0", last_busy, MulBusy);
        end
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        checks++;
        if ({RegDstE, MulStartE, ALUSrcE} !== 3'b100) begin
            errors++;
            $display("FAIL mflo_in_e got regdst/mulstart/alusrc=%b want 100",
                     {RegDstE, MulStartE, ALUSrcE});
        end
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        checks++;
        if ({RegWriteW, HiLoSelW} !== 2'b10) begin
            errors++;
            $display("FAIL mflo_w got regwrite/hilo=%b want 10", {RegWriteW, HiLoSelW});
        end
    endtask

    task automatic test_flush();
        drive_cycle(6'h00, 6'h20, 1'b0, 1'b1, 1'b0, 1'b0, stl);
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if ({ALUControlE, ALUSrcE, RegDstE, LinkE, ImmZeroExtE, MulStartE} !== 9'd0) begin
            errors++;
            $display("FAIL flush_e got %b want 0",
                     {ALUControlE, ALUSrcE, RegDstE, LinkE, ImmZeroExtE, MulStartE});
        end
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if (RegWriteM !== 1'b0) begin
            errors++;
            $display("FAIL flush_m got RegWriteM=%b want 0", RegWriteM);
        end
        // MULT already in E when FlushE arrives must not start the multiplier.
        drive_cycle(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, stl);
        checks++;
        if (MulStartE !== 1'b0) begin
            errors++;
            $display("FAIL flush_mult_start got MulStartE=%b want 0", MulStartE);
        end
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if (MulBusy !== 1'b0) begin
            errors++;
            $display("FAIL flush_mult_busy got MulBusy=%b want 0", MulBusy);
        end
    endtask

    task automatic test_reset_mid_mult();
        drive_cycle(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        drive_cycle(6'h00, 6'h10, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        checks++;
        if ({MulBusy, StallMulD} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_busy got busy/stall=%b want 11", {MulBusy, StallMulD});
        end
        OpCode = 6'h05; Funct = 6'h00; EqualD = 1'b0; StallD = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_mid_mult got=%h want=0", all_outs);
        end
        reset_dut();
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, stl);
        checks++;
        if (MulBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got MulBusy=%b want 0", MulBusy);
        end
    endtask

    task automatic test_perf();
        int n;
        logic [CNT_W-1:0] want_br, want_ms;
        reset_dut();
        drive_cycle(6'h04, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, stl);
        drive_cycle(6'h05, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        drive_cycle(6'h04, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, stl);
        drive_cycle(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        n = 0;
        do begin
            drive_cycle(6'h00, 6'h10, 1'b0, 1'b0, 1'b0, 1'b1, stl);
            n++;
        end while (stl && n < 20);
        drive_cycle(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, stl);
        want_br = PERF_EN ? CNT_W'(3) : '0;
        want_ms = PERF_EN ? CNT_W'(5) : '0;
        checks++;
        if (BrTakenCnt !== want_br) begin
            errors++;
            $display("FAIL perf_br got %0d want %0d", BrTakenCnt, want_br);
        end
        checks++;
        if (MulStallCnt !== want_ms) begin
            errors++;
            $display("FAIL perf_mul got %0d want %0d", MulStallCnt, want_ms);
        end
    endtask

    task automatic test_random();
        logic [5:0]  op, fn;
        logic [11:0] sel;
        logic        eq, fl, st, held;
        held = 1'b0; op = 6'h00; fn = 6'h00; eq = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!held) begin
                if ($urandom_range(0, 9) == 0) begin
                    op = 6'($urandom); fn = 6'($urandom);
                end else begin
                    sel = pick(int'($urandom_range(0, 17)));
                    op = sel[11:6]; fn = sel[5:0];
                end
                eq = 1'($urandom);
            end
            fl = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 11) == 0);
            drive_cycle(op, fn, eq, fl, st, 1'b1, held);

            checks++;
            if ({PCSrcD, jumpD, clearD} !== {exp_pcsrc, exp_jump, exp_clear}) begin
                errors++;
                $display("FAIL rnd%0d_redirect got %b want %b", cyc,
                         {PCSrcD, jumpD, clearD}, {exp_pcsrc, exp_jump, exp_clear});
            end
            checks++;
            if ({StallMulD, MulBusy, MulStartE} !== {exp_stall, exp_busy, exp_start_e}) begin
                errors++;
                $display("FAIL rnd%0d_mul got stall/busy/start=%b want %b", cyc,
                         {StallMulD, MulBusy, MulStartE}, {exp_stall, exp_busy, exp_start_e});
            end
            checks++;
            if ({ALUControlE, ALUSrcE, RegDstE, LinkE, ImmZeroExtE} !==
                {e_exp.alu, e_exp.alu_src, e_exp.reg_dst, e_exp.link, e_exp.zext}) begin
                errors++;
                $display("FAIL rnd%0d_e got %b want %b", cyc,
                         {ALUControlE, ALUSrcE, RegDstE, LinkE, ImmZeroExtE},
                         {e_exp.alu, e_exp.alu_src, e_exp.reg_dst, e_exp.link, e_exp.zext});
            end
            checks++;
            if ({MemWriteM, MemtoRegM, RegWriteM} !==
                {m_exp.mem_write, m_exp.mem_to_reg, m_exp.reg_write}) begin
                errors++;
                $display("FAIL rnd%0d_m got %b want %b", cyc, {MemWriteM, MemtoRegM, RegWriteM},
                         {m_exp.mem_write, m_exp.mem_to_reg, m_exp.reg_write});
            end
            checks++;
            if ({MemtoRegW, RegWriteW, HiLoSelW} !== {w_exp.mem_to_reg, w_exp.reg_write, w_exp.hilo}) begin
                errors++;
                $display("FAIL rnd%0d_w got %b want %b", cyc, {MemtoRegW, RegWriteW, HiLoSelW},
                         {w_exp.mem_to_reg, w_exp.reg_write, w_exp.hilo});
            end
            checks++;
            if ({BrTakenCnt, MulStallCnt} !==
                {(PERF_EN ? CNT_W'(br_cnt) : CNT_W'(0)), (PERF_EN ? CNT_W'(ms_cnt) : CNT_W'(0))}) begin
                errors++;
                $display("FAIL rnd%0d_cnt got br=%0d ms=%0d want br=%0d ms=%0d (perf=%0d)", cyc,
                         BrTakenCnt, MulStallCnt, br_cnt, ms_cnt, PERF_EN);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_lw();
        test_redirect();
        test_mult_mflo();
        test_flush();
        test_reset_mid_mult();
        test_perf();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
